// File: rtl/fxp_sqrt_seq_pkg.sv
// Shared types and constant helpers for the sequential fixed-point square root.
//   state_t   : controller states
//   calc_ni   : integer root bits for a WII-bit signed radicand
//   calc_rb   : total root bits resolved (integer + fraction + round guard)
//   calc_iter : clocks needed to resolve calc_rb bits at bpc bits per clock
//   sat_max   : largest positive value of a signed woi.wof result
package fxp_sqrt_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIN  = 2'd2,
    DONE = 2'd3
  } state_t;

  function automatic int calc_ni(input int wii);
    return (wii + 1) / 2;
  endfunction

  function automatic int calc_rb(input int wii, input int wof, input int rnd);
    return calc_ni(wii) + wof + rnd;
  endfunction

  function automatic int calc_iter(input int rb, input int bpc);
    return (rb + bpc - 1) / bpc;
  endfunction

  function automatic logic [63:0] sat_max(input int woi, input int wof);
    return (64'd1 << (woi + wof - 1)) - 64'd1;
  endfunction

endpackage

// File: rtl/fxp_sqrt_step.sv
// One restoring square-root digit step (purely combinational).
//   i_rem  : partial remainder so far
//   i_root : partial root so far (right-aligned)
//   i_bits : next two radicand bits, MSB first
//   o_rem  : updated remainder
//   o_root : root with one more bit appended
// The remainder is bounded by 2*root, so the NB+2 bit remainder never loses
// significant bits when shifted left by two.
module fxp_sqrt_step #(
  parameter int NB = 18
) (
  input  logic [NB+1:0] i_rem,
  input  logic [NB-1:0] i_root,
  input  logic [1:0]    i_bits,
  output logic [NB+1:0] o_rem,
  output logic [NB-1:0] o_root
);

  logic [NB+3:0] w_cur;
  logic [NB+3:0] w_trial;
  logic [NB+1:0] w_diff;
  logic          w_ge;

  assign w_cur   = {i_rem, i_bits};
  assign w_trial = {2'b00, i_root, 2'b01};
  assign w_ge    = (w_cur >= w_trial);
  // Low bits of the difference are exact whenever the subtract is kept.
  assign w_diff  = w_cur[NB+1:0] - w_trial[NB+1:0];

  assign o_rem  = w_ge ? w_diff : w_cur[NB+1:0];
  assign o_root = {i_root[NB-2:0], w_ge};

endmodule

// File: rtl/fxp_sqrt_seq.sv
// Sequential digit-by-digit fixed-point square root with valid/ready on both
// sides. Signed WII.WIF radicand in, signed WOI.WOF root out, BPC root bits
// resolved per clock.
//   clk, rstn          : clock, synchronous active-low reset
//   i_valid / i_ready  : operand handshake (i_ready also follows o_ready in DONE)
//   in, i_tag          : radicand and user tag, captured on the accepting edge
//   o_valid / o_ready  : result handshake
//   out, o_tag         : root and the tag it belongs to
//   overflow           : root saturated to the largest positive output
//   neg                : radicand was negative (out forced to 0)
module fxp_sqrt_seq
  import fxp_sqrt_seq_pkg::*;
#(
  parameter int WII   = 10,
  parameter int WIF   = 10,
  parameter int WOI   = 6,
  parameter int WOF   = 12,
  parameter int ROUND = 1,
  parameter int BPC   = 1,
  parameter int WTAG  = 4
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 i_valid,
  output logic                 i_ready,
  input  logic [WII+WIF-1:0]   in,
  input  logic [WTAG-1:0]      i_tag,
  output logic                 o_valid,
  input  logic                 o_ready,
  output logic [WOI+WOF-1:0]   out,
  output logic [WTAG-1:0]      o_tag,
  output logic                 overflow,
  output logic                 neg
);

  localparam int RB   = calc_rb(WII, WOF, ROUND);
  localparam int ITER = calc_iter(RB, BPC);
  // Bits actually resolved; any excess over RB shows up as leading zero
  // radicand pairs, so the root value is unaffected.
  localparam int NB   = ITER * BPC;
  localparam int RADW = 2 * NB;
  localparam int RW   = NB + 2;
  localparam int WO   = WOI + WOF;
  localparam int FRAC = 2 * (WOF + ROUND);
  localparam int EW   = RADW + WII + WIF;
  localparam int CW   = (ITER > 1) ? $clog2(ITER) : 1;
  localparam logic [63:0] SATMAX = sat_max(WOI, WOF);

  state_t          r_state, w_state_nx;
  logic [CW-1:0]   r_cnt;
  logic [RADW-1:0] r_rad;
  logic [RW-1:0]   r_rem;
  logic [NB-1:0]   r_root;
  logic [WTAG-1:0] r_tag;
  logic            r_neg;
  logic [WO-1:0]   r_out;
  logic            r_ovf;

  logic            w_accept;
  logic [EW-1:0]   w_ext, w_sh;
  logic [RADW-1:0] w_rad;
  logic [NB:0]     w_rnd;
  logic            w_big;

  // ---------------- radicand alignment ----------------
  // Negative operands still run the full iteration count; their magnitude is
  // irrelevant since the result is forced to zero.
  assign w_ext = in[WII+WIF-1] ? '0 : EW'(in[WII+WIF-2:0]);

  generate
    if (FRAC >= WIF) begin : g_lsh
      assign w_sh = w_ext << (FRAC - WIF);
    end else begin : g_rsh
      assign w_sh = w_ext >> (WIF - FRAC);
    end
  endgenerate

  assign w_rad = RADW'(w_sh);

  // ---------------- step chain ----------------
  logic [RW-1:0] w_rem  [BPC+1];
  logic [NB-1:0] w_root [BPC+1];

  assign w_rem[0]  = r_rem;
  assign w_root[0] = r_root;

  generate
    for (genvar b = 0; b < BPC; b++) begin : g_step
      fxp_sqrt_step #(.NB(NB)) u_step (
        .i_rem  (w_rem[b]),
        .i_root (w_root[b]),
        .i_bits (r_rad[RADW-1-2*b -: 2]),
        .o_rem  (w_rem[b+1]),
        .o_root (w_root[b+1])
      );
    end
  endgenerate

  // ---------------- controller ----------------
  always_ff @(posedge clk) begin
    if (!rstn) r_state <= IDLE;
    else       r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx = r_state;
    i_ready    = 1'b0;
    o_valid    = 1'b0;
    case (r_state)
      IDLE: begin
        i_ready = 1'b1;
        if (i_valid) w_state_nx = CALC;
      end
      CALC: if (r_cnt == '0) w_state_nx = FIN;
      FIN:  w_state_nx = DONE;
      DONE: begin
        o_valid = 1'b1;
        // Result drain and next accept may share one edge.
        i_ready = o_ready;
        if (o_ready) w_state_nx = i_valid ? CALC : IDLE;
      end
      default: w_state_nx = IDLE;
    endcase
  end

  assign w_accept = i_valid & i_ready;

  // ---------------- result rounding / saturation ----------------
  always_comb begin
    w_rnd = {1'b0, r_root};
    if (ROUND != 0) w_rnd = {2'b00, r_root[NB-1:1]} + {{NB{1'b0}}, r_root[0]};
    w_big = 64'(w_rnd) > SATMAX;
  end

  // ---------------- datapath ----------------
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_cnt  <= '0;
      r_rad  <= '0;
      r_rem  <= '0;
      r_root <= '0;
      r_tag  <= '0;
      r_neg  <= 1'b0;
      r_out  <= '0;
      r_ovf  <= 1'b0;
    end else begin
      if (w_accept) begin
        r_cnt  <= CW'(ITER - 1);
        r_rad  <= w_rad;
        r_rem  <= '0;
        r_root <= '0;
        r_tag  <= i_tag;
        r_neg  <= in[WII+WIF-1];
      end else if (r_state == CALC) begin
        r_rad  <= r_rad << (2 * BPC);
        r_rem  <= w_rem[BPC];
        r_root <= w_root[BPC];
        if (r_cnt != '0) r_cnt <= r_cnt - CW'(1);
      end
      if (r_state == FIN) begin
        if (r_neg) begin
          r_out <= '0;
          r_ovf <= 1'b0;
        end else if (w_big) begin
          r_out <= WO'(SATMAX);
          r_ovf <= 1'b1;
        end else begin
          r_out <= WO'(w_rnd);
          r_ovf <= 1'b0;
        end
      end
    end
  end

  assign out      = r_out;
  assign o_tag    = r_tag;
  assign overflow = r_ovf;
  assign neg      = r_neg;

endmodule

// File: tb/tb_fxp_sqrt_seq.sv
// Bench for fxp_sqrt_seq. Four instances share the operand bus:
//   u0 defaults, u1 ROUND=0, u2 WOI=4, u3 BPC=2.
module tb_fxp_sqrt_seq;

  logic        clk  = 1'b0;
  logic        rstn = 1'b0;
  logic        iv   = 1'b0;
  logic        ordy = 1'b0;
  logic [19:0] din  = '0;
  logic [3:0]  itag = '0;

  logic [3:0]  ir, ov, ovf, ng;
  logic [3:0]  otag [4];
  logic [17:0] o0, o1, o3;
  logic [15:0] o2;

  int n_cmp = 0;
  int n_bad = 0;

  logic [17:0] s_out [4];
  logic [3:0]  s_tag [4];
  int          s_lat [4];
  logic [3:0]  s_ovf, s_neg;

  localparam int LAT [4] = '{19, 18, 19, 10};

  always #5 clk = ~clk;

  fxp_sqrt_seq u0 (
    .clk(clk), .rstn(rstn), .i_valid(iv), .i_ready(ir[0]), .in(din), .i_tag(itag),
    .o_valid(ov[0]), .o_ready(ordy), .out(o0), .o_tag(otag[0]), .overflow(ovf[0]), .neg(ng[0]));
  fxp_sqrt_seq #(.ROUND(0)) u1 (
    .clk(clk), .rstn(rstn), .i_valid(iv), .i_ready(ir[1]), .in(din), .i_tag(itag),
    .o_valid(ov[1]), .o_ready(ordy), .out(o1), .o_tag(otag[1]), .overflow(ovf[1]), .neg(ng[1]));
  fxp_sqrt_seq #(.WOI(4)) u2 (
    .clk(clk), .rstn(rstn), .i_valid(iv), .i_ready(ir[2]), .in(din), .i_tag(itag),
    .o_valid(ov[2]), .o_ready(ordy), .out(o2), .o_tag(otag[2]), .overflow(ovf[2]), .neg(ng[2]));
  fxp_sqrt_seq #(.BPC(2)) u3 (
    .clk(clk), .rstn(rstn), .i_valid(iv), .i_ready(ir[3]), .in(din), .i_tag(itag),
    .o_valid(ov[3]), .o_ready(ordy), .out(o3), .o_tag(otag[3]), .overflow(ovf[3]), .neg(ng[3]));

  typedef struct {
    logic [19:0] x;
    logic [3:0]  t;
    logic [17:0] e0;   // defaults (also BPC=2)
    logic [17:0] e1;   // ROUND=0
    logic [15:0] e2;   // WOI=4
    logic        v2;   // WOI=4 overflow
    logic        ng;
  } vec_t;

  typedef struct packed {
    logic [17:0] o;
    logic        ovf;
    logic        neg;
  } res_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    end
  endtask

  // floor(sqrt) reference on the rescaled radicand, then round / saturate.
  function automatic res_t model(input logic [19:0] x, input int rnd, input int woi);
    longint rad, q, mx;
    res_t   r;
    r = '0;
    if (x[19]) begin
      r.neg = 1'b1;
      return r;
    end
    rad = longint'(x) << (2 * (12 + rnd) - 10);
    q   = longint'($rtoi($sqrt(real'(rad))));
    while (q * q > rad) q--;
    while ((q + 1) * (q + 1) <= rad) q++;
    if (rnd != 0) q = (q >> 1) + (q & 1);
    mx = (longint'(1) << (woi + 12 - 1)) - 1;
    if (q > mx) begin
      r.o   = 18'(mx);
      r.ovf = 1'b1;
    end else begin
      r.o = 18'(q);
    end
    return r;
  endfunction

  // Issue one operand to all instances, hold o_ready low until every one has
  // a result, snapshot the outputs, optionally drain.
  task automatic run_op(input logic [19:0] x, input logic [3:0] t, input bit rel);
    int         cyc;
    logic [3:0] seen;
    seen = '0;
    cyc  = 0;
    for (int i = 0; i < 4; i++) s_lat[i] = 0;
    chk("ready_before_op", 32'(ir), 32'hF);
    din = x; itag = t; iv = 1'b1;
    @(posedge clk); #1;
    // i_valid left high with junk: busy instances must not take it
    din = ~x; itag = ~t;
    while (seen != 4'hF && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
      for (int i = 0; i < 4; i++)
        if (ov[i] && !seen[i]) begin
          seen[i]  = 1'b1;
          s_lat[i] = cyc;
        end
    end
    iv = 1'b0;
    chk("all_valid_in_time", 32'(seen), 32'hF);
    s_out[0] = o0; s_out[1] = o1; s_out[2] = 18'(o2); s_out[3] = o3;
    for (int i = 0; i < 4; i++) s_tag[i] = otag[i];
    s_ovf = ovf; s_neg = ng;
    if (rel) begin
      ordy = 1'b1;
      @(posedge clk); #1;
      ordy = 1'b0;
    end
  endtask

  task automatic check_res(input string nm, input logic [3:0] t,
                           input logic [17:0] e0, input logic [17:0] e1, input logic [15:0] e2,
                           input logic v0, input logic v1, input logic v2, input logic en);
    chk($sformatf("%s.out_def", nm), 32'(s_out[0]), 32'(e0));
    chk($sformatf("%s.out_rnd0", nm), 32'(s_out[1]), 32'(e1));
    chk($sformatf("%s.out_woi4", nm), 32'(s_out[2]), 32'(e2));
    chk($sformatf("%s.out_bpc2", nm), 32'(s_out[3]), 32'(e0));
    chk($sformatf("%s.ovf", nm), 32'(s_ovf), 32'({v0, v2, v1, v0}));
    chk($sformatf("%s.neg", nm), 32'(s_neg), 32'({4{en}}));
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("%s.tag%0d", nm, i), 32'(s_tag[i]), 32'(t));
      chk($sformatf("%s.lat%0d", nm, i), 32'(s_lat[i]), 32'(LAT[i]));
    end
  endtask

  task automatic wait_v0(output int lat);
    lat = 0;
    while (!ov[0] && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  vec_t tbl [10];

  initial begin
    int   lat;
    int   stale;
    res_t m0, m1, m2;
    logic [19:0] x;

    tbl[0] = '{20'h00400, 4'h1, 18'h01000, 18'h01000, 16'h1000, 1'b0, 1'b0}; // 1.0
    tbl[1] = '{20'h00800, 4'h2, 18'h016A1, 18'h016A0, 16'h16A1, 1'b0, 1'b0}; // 2.0
    tbl[2] = '{20'h19000, 4'h3, 18'h0A000, 18'h0A000, 16'h7FFF, 1'b1, 1'b0}; // 100.0
    tbl[3] = '{20'h7FFFF, 4'h4, 18'h16A0A, 18'h16A09, 16'h7FFF, 1'b1, 1'b0}; // max positive
    tbl[4] = '{20'hFFC00, 4'h5, 18'h00000, 18'h00000, 16'h0000, 1'b0, 1'b1}; // -1.0
    tbl[5] = '{20'h00000, 4'h6, 18'h00000, 18'h00000, 16'h0000, 1'b0, 1'b0}; // zero
    tbl[6] = '{20'h00001, 4'h7, 18'h00080, 18'h00080, 16'h0080, 1'b0, 1'b0}; // 1 LSB
    tbl[7] = '{20'h80000, 4'h8, 18'h00000, 18'h00000, 16'h0000, 1'b0, 1'b1}; // most negative
    tbl[8] = '{20'h00C00, 4'h9, 18'h01BB6, 18'h01BB6, 16'h1BB6, 1'b0, 1'b0}; // 3.0
    tbl[9] = '{20'h10000, 4'hA, 18'h08000, 18'h08000, 16'h7FFF, 1'b1, 1'b0}; // 8.0 just over WOI=4

    // ---- reset state ----
    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;
    chk("rst.o_valid", 32'(ov), 32'h0);
    chk("rst.i_ready", 32'(ir), 32'hF);
    chk("rst.out0", 32'(o0), 32'h0);
    chk("rst.tag0", 32'(otag[0]), 32'h0);
    chk("rst.ovf", 32'(ovf), 32'h0);
    chk("rst.neg", 32'(ng), 32'h0);

    // ---- directed table ----
    for (int v = 0; v < 10; v++) begin
      run_op(tbl[v].x, tbl[v].t, 1'b1);
      check_res($sformatf("v%0d", v), tbl[v].t, tbl[v].e0, tbl[v].e1, tbl[v].e2,
                1'b0, 1'b0, tbl[v].v2, tbl[v].ng);
    end

    // ---- backpressure: hold the result for 10 cycles ----
    run_op(20'h00800, 4'hA, 1'b0);
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      chk("bp.out", 32'(o0), 32'h016A1);
      chk("bp.tag", 32'(otag[0]), 32'hA);
      chk("bp.i_ready", 32'(ir[0]), 32'h0);
      chk("bp.o_valid", 32'(ov[0]), 32'h1);
    end

    // ---- drain and accept on the same edge, then back-to-back ----
    din = 20'h00400; itag = 4'hB; iv = 1'b1; ordy = 1'b1;
    @(posedge clk); #1;
    chk("b2b.drained", 32'(ov[0]), 32'h0);
    din = 20'h00C00; itag = 4'hC;
    wait_v0(lat);
    chk("b2b.B.lat", 32'(lat), 32'd19);
    chk("b2b.B.out", 32'(o0), 32'h01000);
    chk("b2b.B.tag", 32'(otag[0]), 32'hB);
    @(posedge clk); #1;          // drains B, accepts C
    iv = 1'b0;
    chk("b2b.C.accepted", 32'(ov[0]), 32'h0);
    wait_v0(lat);
    chk("b2b.C.lat", 32'(lat), 32'd19);
    chk("b2b.C.out", 32'(o0), 32'h01BB6);
    chk("b2b.C.tag", 32'(otag[0]), 32'hC);
    repeat (30) @(posedge clk);  // let every instance drain to IDLE
    #1 ordy = 1'b0;

    // ---- reset in the middle of CALC ----
    din = 20'hFFC00; itag = 4'h5; iv = 1'b1;
    @(posedge clk); #1;
    iv = 1'b0;
    repeat (6) @(posedge clk);
    #1 rstn = 1'b0;
    @(posedge clk); #1;
    chk("midrst.o_valid", 32'(ov), 32'h0);
    chk("midrst.i_ready", 32'(ir), 32'hF);
    chk("midrst.out0", 32'(o0), 32'h0);
    chk("midrst.tag0", 32'(otag[0]), 32'h0);
    chk("midrst.ovf", 32'(ovf), 32'h0);
    chk("midrst.neg", 32'(ng), 32'h0);
    rstn = 1'b1;
    stale = 0;
    repeat (25) begin
      @(posedge clk); #1;
      if (ov != 4'h0) stale++;
    end
    chk("midrst.no_stale_valid", 32'(stale), 32'h0);
    run_op(tbl[8].x, 4'h6, 1'b1);
    check_res("postrst", 4'h6, tbl[8].e0, tbl[8].e1, tbl[8].e2, 1'b0, 1'b0, 1'b0, 1'b0);

    // ---- random operands against the real-number model ----
    for (int n = 0; n < 1000; n++) begin
      x  = 20'($urandom());
      m0 = model(x, 1, 6);
      m1 = model(x, 0, 6);
      m2 = model(x, 1, 4);
      run_op(x, 4'(n), 1'b1);
      chk($sformatf("rnd%0d.def", n), 32'(s_out[0]), 32'(m0.o));
      chk($sformatf("rnd%0d.bpc2", n), 32'(s_out[3]), 32'(m0.o));
      chk($sformatf("rnd%0d.rnd0", n), 32'(s_out[1]), 32'(m1.o));
      chk($sformatf("rnd%0d.woi4", n), 32'(s_out[2]), 32'(m2.o));
      chk($sformatf("rnd%0d.flags", n), 32'({s_ovf, s_neg}),
          32'({m0.ovf, m2.ovf, m1.ovf, m0.ovf, {4{m0.neg}}}));
      chk($sformatf("rnd%0d.lat_bpc2", n), 32'(s_lat[3]), 32'd10);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fxp_sqrt_seq.md
Name: fxp_sqrt_seq

Overview:
- Sequential, handshaked fixed-point square root: signed WII.WIF input, signed WOI.WOF output.
- Uses a digit-by-digit (restoring) method that retires BPC result bits per clock. This trades latency for area against the combinational and fully pipelined sqrt blocks.
- Has valid/ready on both sides, a pass-through user tag, and distinct overflow and negative-input flags.
- Sits in the fixed-point library next to the other fxp_* arithmetic blocks.

Parameters:
- WII, 10: input integer bits, including the sign bit.
- WIF, 10: input fractional bits.
- WOI, 6: output integer bits, including the sign bit.
- WOF, 12: output fractional bits.
- ROUND, 1: 1 = round half-up on the output LSB; 0 = truncate.
- BPC, 1: result bits resolved per clock (1 or 2).
- WTAG, 4: width of the user tag carried with each operation (≥1).

Ports:
- clk, input, 1: clock. All logic is on the rising edge.
- rstn, input, 1: synchronous active-low reset.
- i_valid, input, 1: input operand valid.
- i_ready, output, 1: block can accept an operand.
- in, input, WII+WIF: signed radicand.
- i_tag, input, WTAG: user tag, captured with `in`.
- o_valid, output, 1: result valid.
- o_ready, input, 1: downstream accepts the result.
- out, output, WOI+WOF: signed square root.
- o_tag, output, WTAG: tag of this result.
- overflow, output, 1: result saturated to the maximum positive value.
- neg, output, 1: input was negative.

Behaviour:
- Derived constants:
  - NI = (WII+1)/2 integer root bits.
  - RB = NI + WOF + ROUND total root bits.
  - ITER = ceil(RB/BPC).
- Radicand alignment:
  - Magnitude is `in` (non-negative), rescaled to 2*(WOF+ROUND) fractional bits.
  - Left shift when WIF is smaller; truncating right shift when WIF is larger.
  - Radicand register is 2*RB bits.
- States: IDLE, CALC, FIN, DONE.
- Transitions:
  - IDLE: on i_valid & i_ready, load radicand, tag and neg = in[MSB]; clear root and remainder; go to CALC with count = ITER-1.
  - CALC: each edge resolves BPC root bits MSB-first (trial subtract; keep the remainder if non-negative). At count = 0 go to FIN, otherwise decrement count.
  - FIN, one edge, registers the outputs:
    - If ROUND: root = (root >> 1) + root[0].
    - If neg: out = 0, overflow = 0.
    - Else if root > 2^(WOI+WOF-1)-1: out = that maximum, overflow = 1. This includes a round-up carry past the maximum.
    - Else: out = root.
    - Go to DONE.
  - DONE: o_valid = 1; out, o_tag, overflow and neg are held stable. On o_ready, go to IDLE, or straight to CALC if a new operand is accepted on the same edge.
- Negative input still runs the full ITER cycles, so latency is constant.
- i_ready = (state==IDLE) | (state==DONE & o_ready). This is a combinational path o_ready→i_ready and is intended.
- Latency: o_valid rises ITER+1 edges after the accepting edge. Defaults give 19.
- Throughput: one result per ITER+1 cycles when o_ready is held high.
- Inputs are ignored when i_ready = 0. The operand and tag are captured only on the accepting edge.
- Reset, including mid-CALC or in DONE:
  - State returns to IDLE.
  - o_valid = 0, out = 0, o_tag = 0, overflow = 0, neg = 0.
  - i_ready = 1 on the first cycle after reset is released.
  - Any in-flight operation is discarded.
- Zero input gives out = 0 with no flags set.

Decomposition:
- Package fxp_sqrt_seq_pkg holds:
  - state enum (IDLE, CALC, FIN, DONE);
  - constant functions for NI, RB and ITER;
  - the saturation-max helper function.
- Sub-module fxp_sqrt_step is a combinational single-bit restoring step (remainder, root in → remainder, root out), instantiated BPC times in a chain.

Test Plan:
- Defaults, ROUND=1: in=0x00400 (1.0) → out=0x01000 after exactly 19 cycles, no flags, o_tag echoes i_tag.
- in=0x00800 (2.0) → out=0x016A1 with ROUND=1; 0x016A0 with ROUND=0.
- WOI=4: in=0x19000 (100.0) → out=0x7FFF, overflow=1. in=0x7FFFF → out=0x7FFF, overflow=1.
- in=0xFFC00 (-1.0) → out=0, neg=1, overflow=0, latency 19. in=0x00000 → out=0, no flags.
- Backpressure and back-to-back:
  - Hold o_ready=0 for 10 cycles in DONE: out and o_tag stay stable, i_ready=0.
  - Then o_ready=1 with i_valid=1: the next operand is accepted on the same edge, and results arrive every 19 cycles in order with the correct tags.
- Reset asserted mid-CALC (cycle 7):
  - The next edge clears all outputs to 0 and sets i_ready=1.
  - No stale o_valid appears.
  - A fresh operand completes normally.
- BPC=2 with defaults: ITER=9, latency 10, bit-identical results to BPC=1 on 1000 random inputs checked against a floor(sqrt) real-number model.
